shm_client_port: RTL and testbench

// - Initiator side of the SHM toggle trigger/ack protocol; one instance per processor slot of SHM.
// - Converts a processor-side valid/ready request (READ/WRITE/ALLOC/FREE) into a held SHM request plus a trigger toggle.
// - Waits for the ack toggle, captures data_out/ptr_out and returns a single buffered response.
// - At most one request outstanding; a timeout guards against a hung SHM.

---
 rtl/shm_pkg.sv | 25 ++
 rtl/shm_client_port_if.sv | 42 ++++
 rtl/shm_client_port_toggle_tracker.sv | 26 ++
 rtl/shm_client_port.sv | 148 ++++++++++++++
 tb/tb_shm_client_port.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shm_pkg.sv
// Shared SHM geometry, action encoding and client-port state encoding.
// Both the SHM core and its client ports import this package.
package shm_pkg;

  localparam int SIZE        = 16;
  localparam int WORD_SIZE   = 16;
  localparam int PAGE_SIZE   = 4;
  localparam int PAGES_COUNT = SIZE - PAGE_SIZE;

  typedef enum logic [1:0] {
    SHM_READ  = 2'd0,
    SHM_WRITE = 2'd1,
    SHM_ALLOC = 2'd2,
    SHM_FREE  = 2'd3
  } shm_action_t;

  typedef enum logic [2:0] {
    CL_IDLE     = 3'd0,
    CL_WAIT_ACK = 3'd1,
    CL_DELAY    = 3'd2,
    CL_RESP     = 3'd3,
    CL_DRAIN    = 3'd4
  } client_state_t;

endpackage

// File: rtl/shm_client_port_if.sv
// Processor-side request/response channel plus the SHM trigger/ack side of one client slot.
// The master modport is the environment (processor and SHM); the slave modport is the client port.
interface shm_client_port_if;
  import shm_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  shm_action_t            req_action;
  logic [PAGES_COUNT-1:0] req_ptr;
  logic [SIZE-1:0]        req_shift;
  logic [WORD_SIZE-1:0]   req_wdata;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WORD_SIZE-1:0]   rsp_data;
  logic [PAGES_COUNT-1:0] rsp_ptr;
  logic                   rsp_err;

  logic                   shm_trigger;
  logic                   shm_ack;
  shm_action_t            shm_action;
  logic [PAGES_COUNT-1:0] shm_ptr;
  logic [SIZE-1:0]        shm_shift;
  logic [WORD_SIZE-1:0]   shm_data_in;
  logic [WORD_SIZE-1:0]   shm_data_out;
  logic [PAGES_COUNT-1:0] shm_ptr_out;

  modport master (
    output req_valid, req_action, req_ptr, req_shift, req_wdata, rsp_ready,
           shm_ack, shm_data_out, shm_ptr_out,
    input  req_ready, rsp_valid, rsp_data, rsp_ptr, rsp_err,
           shm_trigger, shm_action, shm_ptr, shm_shift, shm_data_in
  );

  modport slave (
    input  req_valid, req_action, req_ptr, req_shift, req_wdata, rsp_ready,
           shm_ack, shm_data_out, shm_ptr_out,
    output req_ready, rsp_valid, rsp_data, rsp_ptr, rsp_err,
           shm_trigger, shm_action, shm_ptr, shm_shift, shm_data_in
  );

endinterface

// File: rtl/shm_client_port_toggle_tracker.sv
// Trigger/ack toggle bookkeeping: flips the trigger level on fire and remembers the ack
// level at that moment, so any later difference on shm_ack means the SHM has answered.
module shm_toggle_tracker (
  input  logic clock,
  input  logic reset,
  input  logic fire,
  input  logic shm_ack,
  output logic ack_seen,
  output logic trigger
);

  logic ack_ref;

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_ref <= 1'b0;
      trigger <= 1'b0;
    end else if (fire) begin
      ack_ref <= shm_ack;
      trigger <= ~trigger;
    end
  end

  assign ack_seen = (shm_ack != ack_ref);

endmodule

// File: rtl/shm_client_port.sv
// Initiator side of the SHM toggle trigger/ack protocol for one processor slot:
// one outstanding request, buffered response, timeout guard against a hung SHM.
module shm_client_port
  import shm_pkg::*;
#(
  parameter int DATA_DELAY     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clock,
  input logic               reset,
  shm_client_port_if.slave  bus
);

  // One counter serves both the ack timeout and the read-data delay; it never runs both at once.
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DD_W  = (DATA_DELAY > 0) ? $clog2(DATA_DELAY + 1) : 1;
  localparam int CNT_W = (TO_W > DD_W) ? TO_W : DD_W;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DD_LAST = CNT_W'((DATA_DELAY > 0) ? DATA_DELAY - 1 : 0);

  client_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_seen;
  logic             fire;
  logic             capture_data;
  logic             capture_ptr;
  logic             set_err;
  logic             timeout_hit;
  logic             delay_done;

  assign bus.req_ready = (state_q == CL_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == CL_RESP);
  assign timeout_hit   = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);
  assign delay_done    = (cnt_q == DD_LAST);

  shm_toggle_tracker u_tracker (
    .clock    (clock),
    .reset    (reset),
    .fire     (fire),
    .shm_ack  (bus.shm_ack),
    .ack_seen (ack_seen),
    .trigger  (bus.shm_trigger)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An ack arriving on the same cycle as the timeout wins, so a slow but live SHM is never flagged.
  always_comb begin
    state_d      = state_q;
    fire         = 1'b0;
    capture_data = 1'b0;
    capture_ptr  = 1'b0;
    set_err      = 1'b0;
    case (state_q)
      CL_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          fire    = 1'b1;
          state_d = CL_WAIT_ACK;
        end
      end
      CL_WAIT_ACK: begin
        if (ack_seen) begin
          capture_ptr = (bus.shm_action == SHM_ALLOC);
          if (bus.shm_action == SHM_READ) begin
            if (DATA_DELAY > 0) begin
              state_d = CL_DELAY;
            end else begin
              capture_data = 1'b1;
              state_d      = CL_RESP;
            end
          end else begin
            state_d = CL_RESP;
          end
        end else if (timeout_hit) begin
          set_err = 1'b1;
          state_d = CL_RESP;
        end
      end
      CL_DELAY: begin
        if (delay_done) begin
          capture_data = 1'b1;
          state_d      = CL_RESP;
        end
      end
      CL_RESP: begin
        if (bus.rsp_ready) begin
          state_d = bus.rsp_err ? CL_DRAIN : CL_IDLE;
        end
      end
      CL_DRAIN: begin
        if (ack_seen) begin
          state_d = CL_IDLE;
        end
      end
      default: state_d = CL_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (fire || ((state_q == CL_WAIT_ACK) && ack_seen)) begin
      cnt_q <= '0;
    end else if (((state_q == CL_WAIT_ACK) || (state_q == CL_DELAY)) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Request fields are held from acceptance until the next acceptance; the response is
  // cleared at acceptance so non-read/non-alloc payload fields naturally read as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.shm_action  <= SHM_READ;
      bus.shm_ptr     <= '0;
      bus.shm_shift   <= '0;
      bus.shm_data_in <= '0;
      bus.rsp_data    <= '0;
      bus.rsp_ptr     <= '0;
      bus.rsp_err     <= 1'b0;
    end else begin
      if (fire) begin
        bus.shm_action  <= bus.req_action;
        bus.shm_ptr     <= bus.req_ptr;
        bus.shm_shift   <= bus.req_shift;
        bus.shm_data_in <= bus.req_wdata;
        bus.rsp_data    <= '0;
        bus.rsp_ptr     <= '0;
        bus.rsp_err     <= 1'b0;
      end
      if (capture_data) begin
        bus.rsp_data <= bus.shm_data_out;
      end
      if (capture_ptr) begin
        bus.rsp_ptr <= bus.shm_ptr_out;
      end
      if (set_err) begin
        bus.rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shm_client_port.sv
// Bench for shm_client_port: SHM behavioural model on the negedge, directed steps with a
// response scoreboard, immediate-assertion comparisons.
module tb_shm_client_port;
  import shm_pkg::*;

  localparam logic [11:0] ALLOC_PTR = 12'h007;

  typedef struct {
    logic [15:0] data;
    logic [11:0] ptr;
    logic        err;
  } rsp_t;

  logic clock;
  logic reset;

  shm_client_port_if bus ();

  shm_client_port #(
    .DATA_DELAY     (1),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int toggles  = 0;
  int ack_lat  = 2;

  rsp_t        sb[$];
  logic [15:0] ref_mem[logic [27:0]];
  logic [15:0] m_mem[logic [27:0]];

  shm_action_t held_act;
  logic [11:0] held_ptr;
  logic [15:0] held_shift;
  logic [15:0] held_wdata;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // SHM model: acks ack_lat cycles after seeing a trigger toggle, read data one cycle after ack.
  initial begin
    logic        m_last;
    int          m_cnt;
    logic        m_data_pend;
    shm_action_t m_act;
    logic [27:0] m_key;
    logic [15:0] m_wd;
    m_last = 1'b0;
    m_cnt = -1;
    m_data_pend = 1'b0;
    m_act = SHM_READ;
    m_key = '0;
    m_wd = '0;
    bus.shm_ack = 1'b0;
    bus.shm_data_out = '0;
    bus.shm_ptr_out = '0;
    m_mem[{12'd3, 16'd5}] = 16'hBEEF;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_last = 1'b0;
        m_cnt = -1;
        m_data_pend = 1'b0;
        bus.shm_ack = 1'b0;
        bus.shm_data_out = '0;
        bus.shm_ptr_out = '0;
      end else begin
        if (m_data_pend) begin
          bus.shm_data_out = m_mem.exists(m_key) ? m_mem[m_key] : 16'h0000;
          m_data_pend = 1'b0;
        end
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_cnt = -1;
            bus.shm_ack = ~bus.shm_ack;
            case (m_act)
              SHM_WRITE: m_mem[m_key] = m_wd;
              SHM_ALLOC: bus.shm_ptr_out = ALLOC_PTR;
              SHM_READ:  m_data_pend = 1'b1;
              default:   ;
            endcase
          end
        end
        if (bus.shm_trigger !== m_last) begin
          m_last = bus.shm_trigger;
          m_cnt = ack_lat;
          m_act = bus.shm_action;
          m_key = {bus.shm_ptr, bus.shm_shift};
          m_wd = bus.shm_data_in;
        end
      end
    end
  end

  initial begin
    logic tprev;
    tprev = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.shm_trigger !== tprev) toggles++;
      tprev = bus.shm_trigger;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one request until accepted; returns at acceptance edge + 1.
  task automatic applyStimulus(input shm_action_t act, input logic [11:0] ptr,
                               input logic [15:0] shift, input logic [15:0] wdata,
                               input bit exp_timeout, input bit push);
    bit          accepted;
    rsp_t        exp;
    logic [27:0] key;
    accepted = 1'b0;
    bus.req_action = act;
    bus.req_ptr = ptr;
    bus.req_shift = shift;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (bus.req_ready) accepted = 1'b1;
      @(posedge clock);
      #1;
    end
    bus.req_valid = 1'b0;
    check("accept", 32'(accepted), 32'd1);
    held_act = act;
    held_ptr = ptr;
    held_shift = shift;
    held_wdata = wdata;
    key = {ptr, shift};
    exp.data = 16'h0000;
    exp.ptr = 12'h000;
    exp.err = 1'b0;
    if (exp_timeout) begin
      exp.err = 1'b1;
    end else begin
      case (act)
        SHM_READ:  exp.data = ref_mem.exists(key) ? ref_mem[key] : 16'h0000;
        SHM_WRITE: ref_mem[key] = wdata;
        SHM_ALLOC: exp.ptr = ALLOC_PTR;
        default:   ;
      endcase
    end
    if (push) sb.push_back(exp);
  endtask

  // Waits for the response, compares with the scoreboard, optionally stalls, then handshakes.
  task automatic checkOutput(input string tag, input int hold, input bit expect_idle, output int lat);
    bit          got;
    bit          ready_seen;
    bit          req_stable;
    bit          held_ok;
    int          tog0;
    rsp_t        exp;
    logic [15:0] d0;
    logic [11:0] p0;
    logic        e0;
    got = 1'b0;
    ready_seen = 1'b0;
    req_stable = 1'b1;
    lat = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clock);
      #1;
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = c;
      end else begin
        if (bus.req_ready) ready_seen = 1'b1;
        if (bus.shm_action !== held_act || bus.shm_ptr !== held_ptr ||
            bus.shm_shift !== held_shift || bus.shm_data_in !== held_wdata)
          req_stable = 1'b0;
      end
    end
    check({tag, "_rsp_valid"}, 32'(got), 32'd1);
    check({tag, "_ready_low_wait"}, 32'(ready_seen), 32'd0);
    check({tag, "_req_held"}, 32'(req_stable), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (got && sb.size() != 0) begin
      exp = sb.pop_front();
      check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp.data));
      check({tag, "_rsp_ptr"}, 32'(bus.rsp_ptr), 32'(exp.ptr));
      check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp.err));
      if (hold > 0) begin
        d0 = bus.rsp_data;
        p0 = bus.rsp_ptr;
        e0 = bus.rsp_err;
        tog0 = toggles;
        held_ok = 1'b1;
        ready_seen = 1'b0;
        bus.req_action = SHM_WRITE;
        bus.req_ptr = 12'd1;
        bus.req_shift = 16'd2;
        bus.req_wdata = 16'h5555;
        bus.req_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(posedge clock);
          #1;
          if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_ptr !== p0 || bus.rsp_err !== e0)
            held_ok = 1'b0;
          if (bus.req_ready) ready_seen = 1'b1;
        end
        bus.req_valid = 1'b0;
        check({tag, "_bp_held"}, 32'(held_ok), 32'd1);
        check({tag, "_bp_ready_low"}, 32'(ready_seen), 32'd0);
        check({tag, "_bp_no_trigger"}, 32'(toggles - tog0), 32'd0);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_dropped"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'(expect_idle));
  endtask

  initial begin
    int  lat;
    int  t0;
    bit  seen;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_action = SHM_READ;
    bus.req_ptr = '0;
    bus.req_shift = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    ref_mem[{12'd3, 16'd5}] = 16'hBEEF;

    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_ptr", 32'(bus.rsp_ptr), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_trigger", 32'(bus.shm_trigger), 32'd0);
    check("rst_shm_req", {bus.shm_action, bus.shm_ptr, bus.shm_shift[1:0]}, 32'd0);
    check("rst_shm_wide", {bus.shm_shift, bus.shm_data_in}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    #1;

    $display("[TB] READ ptr=3 shift=5");
    t0 = toggles;
    applyStimulus(SHM_READ, 12'd3, 16'd5, 16'h0000, 1'b0, 1'b1);
    checkOutput("read", 0, 1'b1, lat);
    check("read_latency", 32'(lat), 32'd4);
    check("read_one_toggle", 32'(toggles - t0), 32'd1);

    $display("[TB] WRITE then READ back-to-back");
    t0 = toggles;
    applyStimulus(SHM_WRITE, 12'd3, 16'd9, 16'h1234, 1'b0, 1'b1);
    check("write_data_in", 32'(bus.shm_data_in), 32'h1234);
    checkOutput("write", 0, 1'b1, lat);
    check("write_latency", 32'(lat), 32'd3);
    check("write_one_toggle", 32'(toggles - t0), 32'd1);
    applyStimulus(SHM_READ, 12'd3, 16'd9, 16'h0000, 1'b0, 1'b1);
    checkOutput("readback", 0, 1'b1, lat);
    check("b2b_two_toggles", 32'(toggles - t0), 32'd2);

    $display("[TB] ALLOC");
    applyStimulus(SHM_ALLOC, 12'd0, 16'd4, 16'h0000, 1'b0, 1'b1);
    checkOutput("alloc", 0, 1'b1, lat);
    check("alloc_latency", 32'(lat), 32'd3);

    $display("[TB] timeout then late ack");
    ack_lat = 20;
    applyStimulus(SHM_FREE, 12'd3, 16'd0, 16'h0000, 1'b1, 1'b1);
    checkOutput("timeout", 0, 1'b0, lat);
    check("timeout_latency", 32'(lat), 32'd8);
    seen = 1'b0;
    for (int c = 10; c <= 20; c++) begin
      @(posedge clock);
      #1;
      if (bus.req_ready) seen = 1'b1;
    end
    check("drain_ready_low", 32'(seen), 32'd0);
    @(posedge clock);
    #1;
    check("drain_exit_ready", 32'(bus.req_ready), 32'd1);
    ack_lat = 2;

    $display("[TB] backpressure");
    applyStimulus(SHM_READ, 12'd3, 16'd5, 16'h0000, 1'b0, 1'b1);
    checkOutput("bp", 5, 1'b1, lat);

    $display("[TB] reset during WAIT_ACK");
    ack_lat = 10;
    applyStimulus(SHM_READ, 12'd3, 16'd5, 16'h0000, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_trigger", 32'(bus.shm_trigger), 32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    ack_lat = 2;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    applyStimulus(SHM_READ, 12'd3, 16'd9, 16'h0000, 1'b0, 1'b1);
    checkOutput("after_rst", 0, 1'b1, lat);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
